// File: rtl/alu_unit.sv
// Registered N-bit integer ALU: one operation per cycle, result and flags
// appear one clock after the operands are presented with in_valid.
module alu_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [3:0]   op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] z,
  output logic         zf,
  output logic         cf,
  output logic         vf,
  output logic         out_valid
);

  localparam int SW = $clog2(N);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_PASSY = 4'd11;

  logic [SW-1:0] sh;
  logic [N:0]    add_w;
  logic [N:0]    sub_w;
  logic          slt_w;
  logic          sltu_w;

  logic [N-1:0]  z_d, z_q;
  logic          cf_d, cf_q;
  logic          vf_d, vf_q;
  logic          valid_q;

  assign sh     = y[SW-1:0];
  assign add_w  = {1'b0, x} + {1'b0, y};
  // Subtraction as x + ~y + 1 so the carry out reads directly as "no borrow".
  assign sub_w  = {1'b0, x} + {1'b0, ~y} + {{N{1'b0}}, 1'b1};
  assign slt_w  = $signed(x) < $signed(y);
  assign sltu_w = x < y;

  always_comb begin
    z_d  = add_w[N-1:0];
    cf_d = add_w[N];
    vf_d = (x[N-1] == y[N-1]) && (add_w[N-1] != x[N-1]);
    case (op)
      OP_ADD: ;
      OP_SUB: begin
        z_d  = sub_w[N-1:0];
        cf_d = sub_w[N];
        vf_d = (x[N-1] != y[N-1]) && (sub_w[N-1] != x[N-1]);
      end
      OP_AND:   begin z_d = x & y;    cf_d = 1'b0; vf_d = 1'b0; end
      OP_OR:    begin z_d = x | y;    cf_d = 1'b0; vf_d = 1'b0; end
      OP_XOR:   begin z_d = x ^ y;    cf_d = 1'b0; vf_d = 1'b0; end
      OP_NOR:   begin z_d = ~(x | y); cf_d = 1'b0; vf_d = 1'b0; end
      OP_SLT:   begin z_d = {{(N-1){1'b0}}, slt_w};  cf_d = 1'b0; vf_d = 1'b0; end
      OP_SLTU:  begin z_d = {{(N-1){1'b0}}, sltu_w}; cf_d = 1'b0; vf_d = 1'b0; end
      OP_SLL:   begin z_d = x << sh;           cf_d = 1'b0; vf_d = 1'b0; end
      OP_SRL:   begin z_d = x >> sh;           cf_d = 1'b0; vf_d = 1'b0; end
      OP_SRA:   begin z_d = $signed(x) >>> sh; cf_d = 1'b0; vf_d = 1'b0; end
      OP_PASSY: begin z_d = y;                 cf_d = 1'b0; vf_d = 1'b0; end
      default: ; // reserved codes fall back to ADD
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q     <= '0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        z_q  <= z_d;
        cf_q <= cf_d;
        vf_q <= vf_d;
      end
    end
  end

  // Zero flag is decoded from the held result, so reset (z=0) yields zf=1.
  assign z         = z_q;
  assign zf        = (z_q == '0);
  assign cf        = cf_q;
  assign vf        = vf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit (N=32): directed cases followed by randomized operations,
// each result checked against an arithmetic reference model.
module tb_alu_unit;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [3:0]   op;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic [N-1:0] z;
  logic         zf;
  logic         cf;
  logic         vf;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_z;
  logic        exp_cf;
  logic        exp_vf;

  alu_unit #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .x         (x),
    .y         (y),
    .z         (z),
    .zf        (zf),
    .cf        (cf),
    .vf        (vf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour from the arithmetic definitions, using 64-bit values.
  task automatic ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic v);
    longint sa;
    longint sb;
    longint s;
    logic [63:0] u;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    c = 1'b0;
    v = 1'b0;
    case (o)
      4'd1: begin
        s = sa - sb;
        r = a - b;
        c = (a >= b);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = 32'(sa >>> sh);
      4'd11: r = b;
      default: begin
        u = {32'b0, a} + {32'b0, b};
        s = sa + sb;
        r = u[31:0];
        c = u[32];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
  endtask

  task automatic check_outputs(input string tag, input logic exp_valid);
    chk({tag, ".z"},         64'(z),         64'(exp_z));
    chk({tag, ".zf"},        64'(zf),        64'(exp_z == 32'd0));
    chk({tag, ".cf"},        64'(cf),        64'(exp_cf));
    chk({tag, ".vf"},        64'(vf),        64'(exp_vf));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
  endtask

  task automatic op_step(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op = o;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    ref_alu(o, a, b, exp_z, exp_cf, exp_vf);
    $display("op=%0d x=%08h y=%08h -> z=%08h zf=%0b cf=%0b vf=%0b v=%0b", o, a, b, z, zf, cf, vf, out_valid);
    check_outputs(tag, 1'b1);
  endtask

  task automatic idle_step(input string tag);
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    x = $urandom;
    y = $urandom;
    @(posedge clk);
    #1;
    $display("idle -> z=%08h zf=%0b cf=%0b vf=%0b v=%0b", z, zf, cf, vf, out_valid);
    check_outputs(tag, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 4'd0;
    x = '0;
    y = '0;
    exp_z = 32'd0;
    exp_cf = 1'b0;
    exp_vf = 1'b0;
    #12;
    $display("reset -> z=%08h zf=%0b v=%0b", z, zf, out_valid);
    check_outputs("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    op_step("add_zero",   4'd0, 32'h0000_0000, 32'h0000_0000);
    op_step("add_basic",  4'd0, 32'h1122_33FF, 32'h0000_0001);
    op_step("add_carry",  4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    op_step("add_ff_ff",  4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_step("add_ovf",    4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    op_step("sub_eq",     4'd1, 32'd5,         32'd5);
    op_step("sub_borrow", 4'd1, 32'd0,         32'd1);
    op_step("sub_ovf",    4'd1, 32'h8000_0000, 32'd1);
    op_step("slt",        4'd6, 32'hFFFF_FFFF, 32'd1);
    op_step("sltu",       4'd7, 32'hFFFF_FFFF, 32'd1);
    op_step("sra",        4'd10, 32'h8000_0000, 32'h0000_0024);
    op_step("srl",        4'd9,  32'h8000_0000, 32'h0000_0024);
    op_step("sll_sh0",    4'd8,  32'hA5A5_1234, 32'hFFFF_FFE0);
    op_step("passy",      4'd11, 32'h1234_5678, 32'hCAFE_0001);
    op_step("reserved",   4'd13, 32'h8000_0000, 32'h8000_0000);

    // Two idle cycles: flags and result must hold.
    idle_step("idle1");
    idle_step("idle2");

    // Asynchronous reset between edges while an operation is presented.
    op_step("pre_rst", 4'd0, 32'd10, 32'd20);
    in_valid = 1'b1;
    op = 4'd0;
    x = 32'h0000_0100;
    y = 32'h0000_0200;
    #2;
    rst_n = 1'b0;
    #1;
    exp_z = 32'd0;
    exp_cf = 1'b0;
    exp_vf = 1'b0;
    $display("async reset -> z=%08h zf=%0b v=%0b", z, zf, out_valid);
    check_outputs("async_rst", 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_hold", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    op_step("post_rst", 4'd0, 32'd3, 32'd4);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'hFFFF_FFFF;
        1: b = a;
        2: a = 32'h7FFF_FFFF;
        3: b = 32'h8000_0000;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0)
        idle_step("rand_idle");
      else
        op_step("rand", 4'($urandom_range(0, 15)), a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
